// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped read-only instruction cache with block refill
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct_mapped #(
  parameter int ADDR_W          = 10,
  parameter int NUM_LINES       = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                                              CLK,
  input  logic                                              RESET,
  input  logic [ADDR_W-1:0]                                 PC,
  output logic [31:0]                                       INSTRUCTION,
  output logic                                              BUSYWAIT,
  output logic                                              mem_read,
  output logic [ADDR_W-3-$clog2(WORDS_PER_BLOCK):0]         mem_address,
  input  logic [32*WORDS_PER_BLOCK-1:0]                     mem_readdata,
  input  logic                                              mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]                                       HIT_COUNT,
  output logic [15:0]                                       MISS_COUNT
`endif
);

  localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int BLK_W  = 32 * WORDS_PER_BLOCK;
  localparam int BA_W   = TAG_W + IDX_W;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLK_W-1:0]     data_q [NUM_LINES];
  logic [BA_W-1:0]      blk_addr_q;
  logic [BLK_W-1:0]     fill_q;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  index;
  logic [OFF_WS-1:0] offset;
  logic [IDX_W-1:0]  fill_index;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              latch_en, capture_en, install_en;
  logic              unused_pc_bits;

  assign tag        = PC[ADDR_W-1 -: TAG_W];
  assign index      = PC[OFF_W+2 +: IDX_W];
  assign fill_index = blk_addr_q[IDX_W-1:0];
  assign fill_tag   = blk_addr_q[BA_W-1 -: TAG_W];
  assign unused_pc_bits = ^PC[1:0];

  generate
    if (OFF_W > 0) begin : g_offset
      assign offset = PC[2 +: OFF_WS];
    end else begin : g_no_offset
      assign offset = '0;
    end
  endgenerate

  assign hit = valid_q[index] && (tag_q[index] == tag);
  assign INSTRUCTION = RESET ? data_q[index][offset*32 +: 32] : 32'd0;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (install_en) valid_q[fill_index] <= 1'b1;
    end
  end

  // Data-path registers carry no reset; the FSM alone decides what gets installed.
  always_ff @(posedge CLK) begin
    if (latch_en)   blk_addr_q <= {tag, index};
    if (capture_en) fill_q     <= mem_readdata;
    if (install_en && RESET) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    BUSYWAIT    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    latch_en    = 1'b0;
    capture_en  = 1'b0;
    install_en  = 1'b0;
    case (state_q)
      IDLE: begin
        BUSYWAIT = !hit;
        if (!hit) begin
          latch_en = 1'b1;
          state_d  = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read    = 1'b1;
        mem_address = blk_addr_q;
        BUSYWAIT    = 1'b1;
        if (!mem_busywait) begin
          capture_en = 1'b1;
          state_d    = UPDATE;
        end
      end
      UPDATE: begin
        BUSYWAIT   = 1'b1;
        install_en = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!RESET) begin
      BUSYWAIT    = 1'b0;
      mem_read    = 1'b0;
      mem_address = '0;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (latch_en && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - directed self-checking bench for icache_direct_mapped
module tb_icache_direct_mapped;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [9:0]   PC = '0;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait = 1'b1;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  int total = 0;
  int bad   = 0;
  int mcnt  = 0;

  icache_direct_mapped dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
    .mem_read(mem_read), .mem_address(mem_address), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
`ifdef ICACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory: busy for 5 cycles after mem_read rises; word i of block a = 0x1000_0000 | a<<16 | i*0x11.
  always @(negedge CLK) begin
    if (mem_read) begin
      mcnt = mcnt + 1;
      mem_busywait = (mcnt < 5);
    end else begin
      mcnt = 0;
      mem_busywait = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      mem_readdata[i*32 +: 32] = 32'h1000_0000 | ({26'd0, mem_address} << 16) | (32'(i) * 32'h11);
  end

  task automatic run_miss(input logic [9:0] pc, input logic [5:0] exp_addr, input logic [31:0] exp_word);
    int n;
    @(negedge CLK);
    RESET = 1'b1;
    PC = pc;
    #1;
    total++; if (BUSYWAIT !== 1'b1) begin bad++; $display("FAIL miss_busy pc=%h: got=%b exp=1", pc, BUSYWAIT); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL miss_idle_rd pc=%h: got=%b exp=0", pc, mem_read); end
    @(negedge CLK); #1;
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL miss_rd pc=%h: got=%b exp=1", pc, mem_read); end
    total++; if (mem_address !== exp_addr) begin bad++; $display("FAIL miss_addr pc=%h: got=%h exp=%h", pc, mem_address, exp_addr); end
    n = 0;
    while (mem_busywait !== 1'b0 && n < 20) begin
      @(negedge CLK); #1;
      n++;
    end
    total++; if (n >= 20) begin bad++; $display("FAIL miss_timeout pc=%h: got=%0d cycles exp<20", pc, n); end
    @(negedge CLK); #1;
    total++; if (BUSYWAIT !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL miss_update pc=%h: got busy=%b rd=%b exp busy=1 rd=0", pc, BUSYWAIT, mem_read); end
    @(negedge CLK); #1;
    total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL miss_done_busy pc=%h: got=%b exp=0", pc, BUSYWAIT); end
    total++; if (INSTRUCTION !== exp_word) begin bad++; $display("FAIL miss_word pc=%h: got=%h exp=%h", pc, INSTRUCTION, exp_word); end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    PC = 10'h00C;
    repeat (2) @(negedge CLK);
    #1;
    total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b exp=0", BUSYWAIT); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL rst_rd: got=%b exp=0", mem_read); end
    total++; if (mem_address !== 6'h00) begin bad++; $display("FAIL rst_addr: got=%h exp=00", mem_address); end
    total++; if (INSTRUCTION !== 32'h0) begin bad++; $display("FAIL rst_instr: got=%h exp=0", INSTRUCTION); end
  endtask

  task automatic test_cold_miss();
    run_miss(10'h000, 6'h00, 32'h1000_0000);
  endtask

  task automatic test_block_hits();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h1000_0000; exp_w[1] = 32'h1000_0011;
    exp_w[2] = 32'h1000_0022; exp_w[3] = 32'h1000_0033;
    for (int i = 1; i < 4; i++) begin
      @(negedge CLK);
      PC = 10'(i * 4);
      #1;
      total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL hit_busy pc=%h: got=%b exp=0", PC, BUSYWAIT); end
      total++; if (INSTRUCTION !== exp_w[i]) begin bad++; $display("FAIL hit_word pc=%h: got=%h exp=%h", PC, INSTRUCTION, exp_w[i]); end
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL hit_rd pc=%h: got=%b exp=0", PC, mem_read); end
    end
  endtask

  task automatic test_conflict();
    run_miss(10'h080, 6'h08, 32'h1008_0000);
    run_miss(10'h000, 6'h00, 32'h1000_0000);
  endtask

  task automatic test_reset_mid_miss();
    @(negedge CLK);
    PC = 10'h100;
    #1;
    total++; if (BUSYWAIT !== 1'b1) begin bad++; $display("FAIL mid_miss_busy: got=%b exp=1", BUSYWAIT); end
    @(negedge CLK); #1;
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL mid_rd_first: got=%b exp=1", mem_read); end
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL mid_rst_rd: got=%b exp=0", mem_read); end
    total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got=%b exp=0", BUSYWAIT); end
    repeat (6) @(negedge CLK);
    run_miss(10'h000, 6'h00, 32'h1000_0000);
    run_miss(10'h100, 6'h10, 32'h1010_0000);
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    total++; if (HIT_COUNT !== 16'd0 || MISS_COUNT !== 16'd0) begin bad++; $display("FAIL stats_rst: got hit=%0d miss=%0d exp 0 0", HIT_COUNT, MISS_COUNT); end
    run_miss(10'h000, 6'h00, 32'h1000_0000);
    test_block_hits();
    @(negedge CLK); #1;
    total++; if (MISS_COUNT !== 16'd1) begin bad++; $display("FAIL stats_miss: got=%0d exp=1", MISS_COUNT); end
    total++; if (HIT_COUNT !== 16'd4) begin bad++; $display("FAIL stats_hit: got=%0d exp=4", HIT_COUNT); end
    repeat (70000) @(posedge CLK);
    @(negedge CLK); #1;
    total++; if (HIT_COUNT !== 16'hFFFF) begin bad++; $display("FAIL stats_sat: got=%h exp=ffff", HIT_COUNT); end
    total++; if (MISS_COUNT !== 16'd1) begin bad++; $display("FAIL stats_miss_after: got=%0d exp=1", MISS_COUNT); end
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_block_hits();
    test_conflict();
    test_reset_mid_miss();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
Parametrised, direct-mapped, read-only instruction cache placed between the CPU's PC/INSTRUCTION fetch port and a multi-cycle block-wide instruction memory. It replaces the zero-wait combinational instruction memory. On a miss it stalls the CPU via BUSYWAIT, fetches a whole block from memory with a read/busywait handshake, and then installs the block. Its geometry (lines, block size, address width) is set by parameters.

Parameters:
ADDR_W, 10, byte-address width of PC used by the cache (upper PC bits ignored)
NUM_LINES, 8, number of cache lines (power of 2, >=2)
WORDS_PER_BLOCK, 4, 32-bit words per block (power of 2, >=1)
Derived: OFF_W=log2(WORDS_PER_BLOCK), IDX_W=log2(NUM_LINES), TAG_W=ADDR_W-2-OFF_W-IDX_W, BLK_W=32*WORDS_PER_BLOCK

Ports:
CLK  input  1  system clock, all state updates on posedge
RESET  input  1  synchronous, active-low reset
PC  input  ADDR_W  fetch byte address from CPU; bits [1:0] ignored
INSTRUCTION  output  32  fetched word; meaningful only when BUSYWAIT=0
BUSYWAIT  output  1  stall request to CPU
mem_read  output  1  block read request to instruction memory
mem_address  output  ADDR_W-2-OFF_W  block address to memory
mem_readdata  input  BLK_W  block from memory; word 0 in bits [31:0]
mem_busywait  input  1  memory busy; data valid on the first posedge with mem_busywait=0 while mem_read=1

Behaviour:
- Address split: offset=PC[OFF_W+1:2], index=PC[OFF_W+IDX_W+1:OFF_W+2], tag=PC[ADDR_W-1:OFF_W+IDX_W+2].
- Per-line storage: valid bit, TAG_W tag, BLK_W data. No dirty bits, no writes from the CPU.
- hit = valid[index] AND tag match. It is combinational from PC.
- INSTRUCTION is a combinational select of the word at offset in line[index]. It is forced to 0 while RESET=0.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - BUSYWAIT = !hit, mem_read = 0.
  - On a miss at a posedge: latch the block address {tag,index} and go to MEM_READ.
  - Hit latency is 0 cycles: same-cycle INSTRUCTION, no stall.
- MEM_READ:
  - mem_read = 1, mem_address = latched block address, BUSYWAIT = 1.
  - Stay while mem_busywait = 1.
  - At a posedge with mem_busywait = 0: capture mem_readdata and go to UPDATE.
- UPDATE:
  - BUSYWAIT = 1, mem_read = 0.
  - At the posedge: write data, tag and valid=1 into the latched index, then go to IDLE.
- Miss penalty: the CPU sees BUSYWAIT fall 2 cycles after the memory completes (UPDATE plus the re-lookup in IDLE).
- PC changing during a miss: the fill completes for the latched address. The new PC is evaluated in IDLE.
- A fill to an occupied index overwrites the line unconditionally.
- Reset (RESET=0 at a posedge), including mid-miss:
  - FSM goes to IDLE and all valid bits clear.
  - Any outstanding memory read is abandoned: mem_read=0 from that edge on, and the returning data is not installed.
  - While RESET=0: BUSYWAIT=0, mem_read=0, mem_address=0, INSTRUCTION=0.
  - Data arrays are not cleared.
- After reset release, the first fetch always misses.

Optional Feature:
ICACHE_STATS_EN
- Defined:
  - Adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both reset to 0.
  - HIT_COUNT increments at each posedge where state=IDLE, RESET=1 and hit=1.
  - MISS_COUNT increments on each IDLE->MEM_READ transition.
  - Both counters saturate at 16'hFFFF with no wrap.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
All tests use default parameters (tag 3b, index 3b, offset 2b, mem_address 6b) and a memory model that holds mem_busywait=1 for 5 cycles after mem_read rises, returning words {W3,W2,W1,W0} = {0x33,0x22,0x11,0x00}-patterned values.

1. Cold miss: reset pulse, PC=0x000.
   - Required: same cycle BUSYWAIT=1; next edge mem_read=1, mem_address=6'h00.
   - Required: after the memory completes, BUSYWAIT=0 exactly 2 cycles later with INSTRUCTION=W0.
2. Block hits: after test 1, PC=0x004, 0x008, 0x00C, one cycle each.
   - Required: BUSYWAIT=0 every cycle, INSTRUCTION=W1/W2/W3, mem_read stays 0.
3. Conflict eviction: PC=0x080 (index 0, tag 1).
   - Required: miss with mem_address=6'h08.
   - Required: then PC=0x000 misses again with mem_address=6'h00.
4. Reset mid-miss: drive RESET=0 on the 2nd cycle of MEM_READ.
   - Required: at that edge mem_read=0 and BUSYWAIT=0.
   - Required: after release, PC=0x000 misses again (valid cleared).
5. Stats (ICACHE_STATS_EN defined): run tests 1 and 2.
   - Required: MISS_COUNT=1, HIT_COUNT=4.
   - Required: after forcing 70000 hit cycles, HIT_COUNT=16'hFFFF.
